if_fetch_queue: RTL

- Decoupling queue between the fetch stage (PC register plus instruction ROM) and the decode stage.
- Captures each fetched {pc, inst} pair in a small FIFO.
- Presents the oldest entry to decode with a valid/ready handshake.
- Back-pressures fetch with a stall signal when full.
- Supports a synchronous flush for branch redirects.

---
 rtl/if_fetch_queue.sv | 125 ++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Fetch-to-decode decoupling FIFO of {pc, inst} pairs. Head entry is presented first-word-fall-through.
// Optional stall performance counter when IFQ_PERF_EN is defined.
module if_fetch_queue #(
   parameter int PTR_W  = 2,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid,
   input  logic [INST_W-1:0] if_pc,
   input  logic [INST_W-1:0] if_inst,
   output logic              if_stall,
   input  logic              flush,
   input  logic              id_ready,
   output logic              id_valid,
   output logic [INST_W-1:0] id_pc,
`ifdef IFQ_PERF_EN
   output logic [31:0]       perf_stall_cnt,
`endif
   output logic [INST_W-1:0] id_inst
);

   localparam int DEPTH = 2 ** PTR_W;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [INST_W-1:0] pc_mem_r   [DEPTH];
   logic [INST_W-1:0] inst_mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W:0]    count_r;
   logic [PTR_W:0]    count_nxt_s;
   logic              push_s;
   logic              pop_s;

   // Handshake qualification; flush suppresses both push and pop.
   always_comb begin
      push_s = if_valid && !if_stall && !flush;
      pop_s  = id_valid && id_ready && !flush;
   end

   // Occupancy next value.
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + {{PTR_W{1'b0}}, 1'b1};
         2'b01:   count_nxt_s = count_r - {{PTR_W{1'b0}}, 1'b1};
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointer and occupancy registers; reset and flush both empty the queue.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         count_r <= count_nxt_s;
      end
   end

   // Storage write; contents are don't-care after reset so no reset is applied.
   always_ff @(posedge clk) begin
      if (push_s && !rst) begin
         pc_mem_r[wr_ptr_r]   <= if_pc;
         inst_mem_r[wr_ptr_r] <= if_inst;
      end
   end

   // Outputs depend only on registered state; empty head reads as zero (NOP).
   always_comb begin
      id_valid = (count_r != '0);
      if_stall = (count_r == FULL_CNT);
      if (id_valid) begin
         id_pc   = pc_mem_r[rd_ptr_r];
         id_inst = inst_mem_r[rd_ptr_r];
      end else begin
         id_pc   = '0;
         id_inst = '0;
      end
   end

`ifdef IFQ_PERF_EN
   logic [31:0] perf_stall_cnt_r;

   // Saturating count of cycles in which fetch was refused; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt_r <= 32'h0000_0000;
      end else if (if_valid && if_stall && (perf_stall_cnt_r != 32'hFFFF_FFFF)) begin
         perf_stall_cnt_r <= perf_stall_cnt_r + 32'h0000_0001;
      end
   end

   assign perf_stall_cnt = perf_stall_cnt_r;
`endif

   if_fetch_queue_chk #(.PTR_W(PTR_W)) u_chk (
      .clk   (clk),
      .rst   (rst),
      .count (count_r)
   );

endmodule

// Occupancy bound checker; an underflow would wrap the count above DEPTH and trip the same check.
module if_fetch_queue_chk #(
   parameter int PTR_W = 2
) (
   input logic             clk,
   input logic             rst,
   input logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(2 ** PTR_W);

   a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT)
      else $error("if_fetch_queue count out of range: %0d", count);

endmodule
